// File: rtl/mc_processor_p.sv
// mc_processor_p: parametrised multi-cycle core (FETCH/DECODE/MEM/WB/HALT) with a
// ready-qualified memory handshake; the top register doubles as the PC.
module mc_processor_p #(
    parameter int DW   = 16,
    parameter int NREG = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [DW-1:0] DataIn,
    input  logic          MemReady,
    output logic          MemReq,
    output logic          W,
    output logic [DW-1:0] Daddress,
    output logic [DW-1:0] Dout,
    output logic          Halted
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [2:0] {FETCH, DECODE, MEM, WB, HALT} state_t;

    state_t        state;
    logic [DW-1:0] r [NREG];
    logic [15:0]   ir;
    logic [DW-1:0] addr, mdr, alur;
    logic [DW-1:0] pc, va, vb, vd, alu, wdata;
    logic [3:0]    op, rd, ra, rb;
    logic          wen;

    assign op = ir[15:12];
    assign rd = ir[11:8];
    assign ra = ir[7:4];
    assign rb = ir[3:0];
    assign pc = r[NREG-1];

    // Indices beyond the register file read as zero
    assign va = int'(ra) < NREG ? r[ra[AW-1:0]] : '0;
    assign vb = int'(rb) < NREG ? r[rb[AW-1:0]] : '0;
    assign vd = int'(rd) < NREG ? r[rd[AW-1:0]] : '0;

    assign alu = op == 4'h0 ? va + vb :
                 op == 4'h1 ? va | vb :
                 op == 4'h2 ? va & vb :
                 op == 4'h3 ? ~va :
                 op == 4'h4 ? va - vb : va ^ vb;

    assign wen = op < 4'h6 || op == 4'hD || op == 4'hE || op == 4'hF || (op == 4'hB && vb != '0);
    assign wdata = (op == 4'hD || op == 4'hF) ? mdr : (op == 4'hB || op == 4'hE) ? va : alur;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FETCH;
            ir    <= '0;
            addr  <= '0;
            mdr   <= '0;
            alur  <= '0;
            for (int i = 0; i < NREG; i++) r[i] <= '0;
        end else begin
            case (state)
                FETCH: if (MemReady) begin
                    ir         <= DataIn[15:0];
                    r[NREG-1]  <= pc + DW'(1);
                    state      <= DECODE;
                end
                DECODE: begin
                    if (op < 4'h6) begin
                        alur  <= alu;
                        state <= WB;
                    end else if (op == 4'hC || op == 4'hD) begin
                        addr  <= va;
                        state <= MEM;
                    end else if (op == 4'hF) begin
                        addr  <= pc;
                        state <= MEM;
                    end else if (op == 4'hB || op == 4'hE) state <= WB;
                    else if (op == 4'h7) state <= HALT;
                    else state <= FETCH;
                end
                MEM: if (MemReady) begin
                    if (op == 4'hC) state <= FETCH;
                    else begin
                        mdr   <= DataIn;
                        state <= WB;
                        if (op == 4'hF) r[NREG-1] <= pc + DW'(1);
                    end
                end
                // A write to the PC here supersedes any earlier increment
                WB: begin
                    if (wen && int'(rd) < NREG) r[rd[AW-1:0]] <= wdata;
                    state <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    assign MemReq   = state == FETCH || state == MEM;
    assign W        = state == MEM && op == 4'hC;
    assign Daddress = state == FETCH ? pc : state == MEM ? addr : '0;
    assign Dout     = W ? vd : '0;
    assign Halted   = state == HALT;
endmodule

// File: tb/tb_mc_processor_p.sv
// tb_mc_processor_p: directed vectors for a 16-bit/16-register core and a
// 32-bit/8-register core, each with its own 256-word memory model.
module tb_mc_processor_p;
    logic        Clock, Reset;
    logic        rdy, clr, pwe, psel;
    logic [7:0]  pa;
    logic [31:0] pd;
    logic [15:0] mem16 [256];
    logic [31:0] mem32 [256];

    logic        mem_req, w, halted;
    logic [15:0] data_in, daddr, dout;
    logic        mem_req32, w32, halted32;
    logic [31:0] data_in32, daddr32, dout32;

    int tests = 0;
    int fails = 0;
    int n;
    logic [31:0] pq [$];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;
    vec_t vt [14];

    mc_processor_p #(.DW(16), .NREG(16)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(data_in), .MemReady(rdy),
        .MemReq(mem_req), .W(w), .Daddress(daddr), .Dout(dout), .Halted(halted)
    );

    mc_processor_p #(.DW(32), .NREG(8)) dut32 (
        .Clock(Clock), .Reset(Reset), .DataIn(data_in32), .MemReady(1'b1),
        .MemReq(mem_req32), .W(w32), .Daddress(daddr32), .Dout(dout32), .Halted(halted32)
    );

    initial Clock = 0;
    always #5 Clock = ~Clock;

    assign data_in   = mem16[daddr[7:0]];
    assign data_in32 = mem32[daddr32[7:0]];

    always @(posedge Clock) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) begin
                mem16[i] <= '0;
                mem32[i] <= '0;
            end
        end else if (pwe) begin
            if (psel) mem32[pa] <= pd;
            else mem16[pa] <= pd[15:0];
        end else begin
            if (mem_req && w && rdy) mem16[daddr[7:0]] <= dout;
            if (mem_req32 && w32) mem32[daddr32[7:0]] <= dout32;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Hold the cores in reset while the program in pq is written, then release
    task automatic start(input logic sel);
        Reset = 1;
        clr = 1;
        @(negedge Clock);
        clr = 0;
        for (int i = 0; i < pq.size(); i++) begin
            pwe = 1;
            psel = sel;
            pa = 8'(i);
            pd = pq[i];
            @(negedge Clock);
        end
        pwe = 0;
        Reset = 0;
    endtask

    task automatic wait_halt(input logic sel, input string nm);
        int k = 0;
        while (!(sel ? halted32 : halted) && k < 3000) begin
            @(negedge Clock);
            k++;
        end
        check(nm, 64'(sel ? halted32 : halted), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Reset = 1; rdy = 1; clr = 0; pwe = 0; psel = 0; pa = '0; pd = '0;
        vt[0]  = '{16'h0312, 16'h0005, 16'h0003, 16'h0008};
        vt[1]  = '{16'h0312, 16'hFFFF, 16'h0001, 16'h0000};
        vt[2]  = '{16'h1312, 16'h00F0, 16'h0F0F, 16'h0FFF};
        vt[3]  = '{16'h2312, 16'h00F0, 16'h0FF0, 16'h00F0};
        vt[4]  = '{16'h3312, 16'h1234, 16'h0000, 16'hEDCB};
        vt[5]  = '{16'h4312, 16'h0003, 16'h0005, 16'hFFFE};
        vt[6]  = '{16'h4312, 16'h0009, 16'h0004, 16'h0005};
        vt[7]  = '{16'h5312, 16'hFF00, 16'h0FF0, 16'hF0F0};
        vt[8]  = '{16'hB312, 16'h1234, 16'h0000, 16'h5A5A};
        vt[9]  = '{16'hB312, 16'h1234, 16'h0001, 16'h1234};
        vt[10] = '{16'hE312, 16'h4321, 16'h0000, 16'h4321};
        vt[11] = '{16'h6312, 16'h1111, 16'h2222, 16'h5A5A};
        vt[12] = '{16'hA312, 16'h1111, 16'h2222, 16'h5A5A};
        vt[13] = '{16'hD310, 16'h0006, 16'h0000, 16'hD310};

        // Basic program, reset outputs, ADD latency, register dump via stores
        pq = '{'hF100, 'h0005, 'hF200, 'h0003, 'h0312, 'h4412, 'hF700, 'h0080, 'hF800, 'h0001,
               'hC170, 'h0778, 'hC270, 'h0778, 'hC370, 'h0778, 'hC470, 'h7000};
        start(0);
        check("reset_out", 64'({mem_req, w, daddr, dout, halted}), 64'({1'b1, 1'b0, 16'h0, 16'h0, 1'b0}));
        check("reset_out32", 64'({mem_req32, w32, daddr32, halted32}), 64'({1'b1, 1'b0, 32'h0, 1'b0}));
        n = 0;
        while (!(mem_req && !w && daddr == 16'h4) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!(mem_req && !w && daddr == 16'h5) && n < 20);
        check("add_latency", 64'(n), 64'd3);
        wait_halt(0, "t1_halt");
        check("t1_r1", 64'(mem16[8'h80]), 64'h5);
        check("t1_r2", 64'(mem16[8'h81]), 64'h3);
        check("t1_r3", 64'(mem16[8'h82]), 64'h8);
        check("t1_r4", 64'(mem16[8'h83]), 64'h2);

        // Table: R1=a, R2=b, R3=5A5A, instr, then store R3 at 0x80
        for (int i = 0; i < 14; i++) begin
            pq = '{'hF100, {16'h0, vt[i].a}, 'hF200, {16'h0, vt[i].b}, 'hF300, 'h5A5A,
                   {16'h0, vt[i].instr}, 'hF400, 'h0080, 'hC340, 'h7000};
            start(0);
            wait_halt(0, $sformatf("vec%0d_halt", i));
            check($sformatf("vec%0d_%h", i, vt[i].instr), 64'(mem16[8'h80]), 64'(vt[i].exp));
        end

        // STORE with two wait states, then LOAD back
        pq = '{'hF100, 'h0020, 'hF300, 'h00AB, 'hC310, 'hD510, 'hF600, 'h0021, 'hC560, 'h7000};
        start(0);
        n = 0;
        while (!(mem_req && w) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        rdy = 0;
        check("st_wait0", 64'({mem_req, w, daddr, dout}), 64'({1'b1, 1'b1, 16'h0020, 16'h00AB}));
        @(negedge Clock);
        check("st_wait1", 64'({mem_req, w, daddr, dout}), 64'({1'b1, 1'b1, 16'h0020, 16'h00AB}));
        check("st_nowrite", 64'(mem16[8'h20]), 64'h0);
        @(negedge Clock);
        check("st_wait2", 64'({mem_req, w, daddr, dout}), 64'({1'b1, 1'b1, 16'h0020, 16'h00AB}));
        rdy = 1;
        @(negedge Clock);
        check("st_done", 64'({mem_req, w, daddr}), 64'({1'b1, 1'b0, 16'h0005}));
        check("st_mem", 64'(mem16[8'h20]), 64'hAB);
        wait_halt(0, "st_halt");
        check("ld_back", 64'(mem16[8'h21]), 64'hAB);

        // COPY into PC is a jump
        pq = '{'hF100, 'h0040, 'hEF10};
        while (pq.size() < 'h40) pq.push_back('h0);
        pq.push_back('h7000);
        start(0);
        n = 0;
        while (!(mem_req && !w && daddr == 16'h2) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        repeat (3) @(negedge Clock);
        check("jump_fetch", 64'({mem_req, w, daddr}), 64'({1'b1, 1'b0, 16'h0040}));
        wait_halt(0, "jump_halt");

        // HALT holds until reset
        pq = '{'h7000};
        start(0);
        wait_halt(0, "halt_reach");
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            check($sformatf("halt_hold%0d", i), 64'({halted, mem_req, w, daddr}), 64'({1'b1, 1'b0, 1'b0, 16'h0}));
        end
        Reset = 1;
        @(negedge Clock);
        Reset = 0;
        check("halt_reset", 64'({mem_req, w, daddr, halted}), 64'({1'b1, 1'b0, 16'h0, 1'b0}));

        // Reset while a STORE waits on memory
        pq = '{'hF100, 'h0055, 'hF200, 'h0090, 'hC120, 'h7000};
        start(0);
        n = 0;
        while (!(mem_req && w) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        rdy = 0;
        @(negedge Clock);
        Reset = 1;
        @(negedge Clock);
        Reset = 0;
        rdy = 1;
        check("rst_mid", 64'({mem_req, w, daddr}), 64'({1'b1, 1'b0, 16'h0}));
        check("rst_mid_mem", 64'(mem16[8'h90]), 64'h0);
        wait_halt(0, "rst_mid_halt");
        check("rst_rerun", 64'(mem16[8'h90]), 64'h55);

        // 32-bit core, 8 registers: SUB wrap, dropped write, out-of-range read
        pq = '{'hF100, 'h0, 'hF200, 'h1, 'hDEAD4612, 'hF300, 'h1234, 'hE9A0, 'hE3A0,
               'hF500, 'h80, 'hC650, 'h0552, 'hC350, 'h0552, 'hC150, 'h7000};
        while (pq.size() < 'h80) pq.push_back('h0);
        pq.push_back('hDDDDDDDD);
        pq.push_back('hDDDDDDDD);
        pq.push_back('hDDDDDDDD);
        start(1);
        wait_halt(1, "w32_halt");
        check("w32_sub", 64'(mem32[8'h80]), 64'hFFFFFFFF);
        check("w32_rd10", 64'(mem32[8'h81]), 64'h0);
        check("w32_drop", 64'(mem32[8'h82]), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
